// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler: opcodes, FSM states
// and the fixed result values used when the divider is bypassed.
package div_sched_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Two-way round-robin grant. The grant is combinational; the priority only
// moves when a granted request is actually taken.
module div_rr_arb (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester that wins a tie; the loser of the last grant.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[prio]) begin
                gnt[prio] = 1'b1;
            end else if (req[~prio]) begin
                gnt[~prio] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= 1'b0;
        end else if (|(req & gnt)) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one external iterative divider between two requesters. Divide-by-zero
// and signed overflow are answered locally without starting the divider.
module div_sched
    import div_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][1:0]  req_op,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             div_enable,
    input  logic             div_completed,
    output logic             div_is_signed,
    output logic [31:0]      div_src,
    output logic [31:0]      div_sink,
    input  logic [31:0]      div_quo,
    input  logic [31:0]      div_res
);

    div_state_e  state;
    div_op_e     op_q;
    logic        idx_q;

    logic        arb_en;
    logic [1:0]  gnt;
    logic        accept;
    logic        acc_idx;
    div_op_e     acc_op;
    logic [31:0] acc_a;
    logic [31:0] acc_b;
    logic        acc_zero;
    logic        acc_ovf;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Fixed answers for the two cases the divider is never asked about.
    function automatic logic [31:0] bypass_result(input div_op_e op, input logic [31:0] a,
                                                  input logic zero);
        if (zero) begin
            return op_is_rem(op) ? a : ALL_ONES;
        end
        return op_is_rem(op) ? 32'd0 : INT_MIN;
    endfunction

    assign arb_en = (state == ST_IDLE) && rstn;

    div_rr_arb u_arb (
        .clk  (clk),
        .rstn (rstn),
        .en   (arb_en),
        .req  (req_valid),
        .gnt  (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign acc_idx   = gnt[1];
    assign acc_op    = div_op_e'(req_op[acc_idx]);
    assign acc_a     = req_a[acc_idx];
    assign acc_b     = req_b[acc_idx];
    assign acc_zero  = (acc_b == '0);
    assign acc_ovf   = op_is_signed(acc_op) && (acc_a == INT_MIN) && (acc_b == ALL_ONES);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            op_q          <= OP_DIV;
            idx_q         <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_data      <= '0;
            div_enable    <= 1'b0;
            div_is_signed <= 1'b0;
            div_src       <= '0;
            div_sink      <= '0;
        end else begin
            div_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= acc_op;
                        idx_q <= acc_idx;
                        if (acc_zero || acc_ovf) begin
                            rsp_data  <= bypass_result(acc_op, acc_a, acc_zero);
                            rsp_valid <= onehot(acc_idx);
                            state     <= ST_RESP;
                        end else begin
                            div_src       <= acc_a;
                            div_sink      <= acc_b;
                            div_is_signed <= op_is_signed(acc_op);
                            div_enable    <= 1'b1;
                            state         <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                // Completion is only meaningful here; elsewhere it is stale or spurious.
                ST_WAIT: begin
                    if (div_completed) begin
                        rsp_data  <= op_is_rem(op_q) ? div_res : div_quo;
                        rsp_valid <= onehot(idx_q);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[idx_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed vector table, multi-cycle corner sequences and
// a randomized run against a behavioural model, with an external divider model.
module tb_div_sched;
    import div_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_data;
    logic             div_enable;
    logic             div_completed;
    logic             div_is_signed;
    logic [31:0]      div_src;
    logic [31:0]      div_sink;
    logic [31:0]      div_quo;
    logic [31:0]      div_res;

    logic model_cmpl;
    logic spur_cmpl;
    assign div_completed = model_cmpl | spur_cmpl;

    int checks   = 0;
    int errors   = 0;
    int en_count = 0;
    int div_lat  = 1;

    logic [31:0] m_src;
    logic [31:0] m_sink;
    logic        m_sg;
    logic [63:0] m_qr;

    always #5 clk = ~clk;

    div_sched dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .div_enable    (div_enable),
        .div_completed (div_completed),
        .div_is_signed (div_is_signed),
        .div_src       (div_src),
        .div_sink      (div_sink),
        .div_quo       (div_quo),
        .div_res       (div_res)
    );

    // Division with the usual RISC-V conventions for zero divisor and overflow.
    function automatic logic [63:0] div_math(input logic sg, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = ALL_ONES;
            r = a;
        end else if (sg && a == INT_MIN && b == ALL_ONES) begin
            q = INT_MIN;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] qr;
        qr = div_math(op == 2'd0 || op == 2'd2, a, b);
        return (op >= 2'd2) ? qr[31:0] : qr[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // External divider: answers div_lat cycles after each start pulse.
    initial begin
        model_cmpl = 1'b0;
        div_quo    = '0;
        div_res    = '0;
        forever begin
            @(negedge clk);
            if (div_enable === 1'b1) begin
                m_src  = div_src;
                m_sink = div_sink;
                m_sg   = div_is_signed;
                repeat (div_lat) @(negedge clk);
                m_qr       = div_math(m_sg, m_src, m_sink);
                div_quo    = m_qr[63:32];
                div_res    = m_qr[31:0];
                model_cmpl = 1'b1;
                @(negedge clk);
                model_cmpl = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (div_enable === 1'b1) en_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        spur_cmpl = 1'b0;
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        rstn      = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_div_enable", 32'(div_enable), 32'd0);
        chk("rst_div_is_signed", 32'(div_is_signed), 32'd0);
        chk("rst_div_src", div_src, 32'd0);
        chk("rst_div_sink", div_sink, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00;
        rstn      = 1'b1;
    endtask

    task automatic run_one(input string tag, input logic idx, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input logic byp);
        int         en0;
        int         waited;
        logic [1:0] oh;
        logic       sg;
        oh = idx ? 2'b10 : 2'b01;
        sg = (op == 2'd0) || (op == 2'd2);
        req_op[idx] = op;
        req_a[idx]  = a;
        req_b[idx]  = b;
        req_valid   = oh;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        en0 = en_count;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        if (byp) begin
            chk({tag, "_bypass_lat"}, 32'(rsp_valid), 32'(oh));
        end else begin
            chk({tag, "_enable"}, 32'(div_enable), 32'd1);
            chk({tag, "_signed"}, 32'(div_is_signed), 32'(sg));
            chk({tag, "_src"}, div_src, a);
            chk({tag, "_sink"}, div_sink, b);
        end
        waited = 0;
        while (rsp_valid == 2'b00 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, "_rsp_data"}, rsp_data, exp);
        chk({tag, "_enables"}, 32'(en_count - en0), byp ? 32'd0 : 32'd1);
        rsp_ready = oh;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        chk({tag, "_release"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic new_req(input int i, input bit en);
        int mode;
        req_valid[i] = en && ($urandom_range(0, 3) != 0);
        req_op[i]    = 2'($urandom_range(0, 3));
        mode         = $urandom_range(0, 5);
        case (mode)
            0: begin req_a[i] = $urandom; req_b[i] = 32'd0; end
            1: begin req_a[i] = INT_MIN; req_b[i] = ALL_ONES; end
            2: begin req_a[i] = $urandom_range(0, 1000); req_b[i] = $urandom_range(1, 20); end
            3: begin req_a[i] = $urandom; req_b[i] = ALL_ONES - $urandom_range(0, 5); end
            default: begin req_a[i] = $urandom; req_b[i] = $urandom; end
        endcase
    endtask

    task automatic random_phase(input int ncyc);
        logic        busy;
        logic        last;
        logic        exp_idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_rdy;
        logic        done;
        int          acc;
        busy     = 1'b0;
        last     = 1'b1;
        exp_idx  = 1'b0;
        exp_data = '0;
        done     = 1'b0;
        acc      = -1;
        for (int i = 0; i < 2; i++) new_req(i, 1'b1);
        for (int cyc = 0; cyc < ncyc + 200; cyc++) begin
            #1;
            exp_rdy = 2'b00;
            if (!busy) begin
                if (req_valid == 2'b11) exp_rdy = last ? 2'b01 : 2'b10;
                else exp_rdy = req_valid;
            end
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
            if (!busy) begin
                chk("rnd_idle_rsp", 32'(rsp_valid), 32'd0);
            end else if (rsp_valid != 2'b00) begin
                chk("rnd_rsp_idx", 32'(rsp_valid), exp_idx ? 32'd2 : 32'd1);
                chk("rnd_rsp_data", rsp_data, exp_data);
            end
            acc = -1;
            for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) acc = i;
            done = busy && (|(rsp_valid & rsp_ready));
            if (cyc >= ncyc && !busy && acc < 0) break;
            @(posedge clk);
            #1;
            if (done) busy = 1'b0;
            if (acc >= 0) begin
                busy     = 1'b1;
                exp_idx  = acc[0];
                last     = acc[0];
                exp_data = ref_result(req_op[acc], req_a[acc], req_b[acc]);
                new_req(acc, cyc < ncyc);
            end
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && cyc < ncyc && $urandom_range(0, 2) == 0) new_req(i, 1'b1);
            end
            if (cyc >= ncyc) req_valid = 2'b00;
            rsp_ready = (cyc >= ncyc) ? 2'b11 : 2'($urandom_range(0, 3));
            spur_cmpl = !busy && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) div_lat = $urandom_range(1, 4);
        end
        spur_cmpl = 1'b0;
        req_valid = 2'b00;
        chk("rnd_drained", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        idx;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        byp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int         en0;
        int         g;
        int         r;
        logic [1:0] oh;

        vecs[0]  = '{1'b0, 2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0};
        vecs[1]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 1'b1};
        vecs[2]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{1'b0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4]  = '{1'b0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b1, 2'd2, 32'd7,         32'd0,        32'd7,         1'b1};
        vecs[6]  = '{1'b0, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{1'b0, 2'd3, 32'd100,       32'd7,        32'd2,         1'b0};
        vecs[9]  = '{1'b1, 2'd0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0};
        vecs[11] = '{1'b1, 2'd0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0};

        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            div_lat = 1 + (i % 3);
            run_one($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].byp);
        end

        // Response held under backpressure, spurious completions ignored.
        req_op[1] = 2'd1;
        req_a[1]  = 32'd5;
        req_b[1]  = 32'd0;
        req_valid = 2'b10;
        en0 = en_count;
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            spur_cmpl = (c == 2);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd2);
            chk("hold_rsp_data", rsp_data, 32'hFFFF_FFFF);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_div_enable", 32'(div_enable), 32'd0);
            @(posedge clk);
            #1;
        end
        spur_cmpl = 1'b0;
        rsp_ready = 2'b10;
        #1;
        chk("hold_release_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        chk("hold_release_valid", 32'(rsp_valid), 32'd0);
        spur_cmpl = 1'b1;
        @(posedge clk);
        #1;
        spur_cmpl = 1'b0;
        chk("idle_spurious_rsp", 32'(rsp_valid), 32'd0);
        chk("hold_enables", 32'(en_count - en0), 32'd0);

        // Both requesters valid from reset: grants alternate starting at 0.
        do_reset();
        div_lat   = 2;
        req_op    = {2'd1, 2'd1};
        req_a     = {32'd100, 32'd100};
        req_b     = {32'd7, 32'd7};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        g = 0;
        r = 0;
        for (int cyc = 0; cyc < 200 && r < 4; cyc++) begin
            if (req_ready != 2'b00 && g < 4) begin
                chk("rr_grant", 32'(req_ready), (g % 2 == 1) ? 32'd2 : 32'd1);
                g++;
            end
            if (rsp_valid != 2'b00) begin
                chk("rr_rsp_idx", 32'(rsp_valid), (r % 2 == 1) ? 32'd2 : 32'd1);
                chk("rr_rsp_data", rsp_data, 32'd14);
                r++;
            end
            @(posedge clk);
            #1;
        end
        chk("rr_grant_count", 32'(g), 32'd4);
        chk("rr_rsp_count", 32'(r), 32'd4);
        req_valid = 2'b00;

        do_reset();
        random_phase(3000);

        // Reset while waiting on the divider; the late completion must vanish.
        do_reset();
        div_lat   = 4;
        req_op[0] = 2'd1;
        req_a[0]  = 32'd1000;
        req_b[0]  = 32'd3;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("late_cmpl_rsp", 32'(rsp_valid), 32'd0);
            chk("late_cmpl_enable", 32'(div_enable), 32'd0);
        end
        div_lat = 1;
        run_one("after_rst", 1'b0, 2'd3, 32'd10, 32'd3, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
